// File: rtl/gsim_iter_ctrl_if.sv
// Update-datapath / x-memory link between the GSIM sequencer (master)
// and the shared row-update datapath plus x-memory (slave).
interface gsim_iter_ctrl_if;
  logic        upd_start;
  logic [3:0]  upd_row;
  logic        upd_done;
  logic [31:0] upd_delta;
  logic [3:0]  x_raddr;
  logic [31:0] x_rdata;

  modport master (
    output upd_start, upd_row, x_raddr,
    input  upd_done, upd_delta, x_rdata
  );

  modport slave (
    input  upd_start, upd_row, x_raddr,
    output upd_done, upd_delta, x_rdata
  );
endinterface

// File: rtl/gsim_iter_ctrl.sv
// GSIM Gauss-Seidel iteration sequencer.
// Loads the 16-word b vector, issues one row update per row per iteration,
// tracks iteration count / max |dx| and streams the x vector out.
// Optional feature macro: GSIM_CTRL_EARLY_EXIT_EN (early exit on convergence).
module gsim_iter_ctrl #(
  parameter int unsigned N_ROW    = 16,
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned MIN_ITER = 4,
  parameter logic [31:0] TOL      = 32'h0000_0010
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic [15:0]             b_in,
  output logic                    b_we,
  output logic [3:0]              b_waddr,
  output logic [15:0]             b_wdata,
  gsim_iter_ctrl_if.master        dp,
  output logic                    out_valid,
  output logic [31:0]             x_out,
  output logic                    busy,
  output logic [6:0]              iter_cnt
);

`ifdef GSIM_CTRL_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  localparam logic [3:0] LAST_ROW = 4'(N_ROW - 1);
  localparam logic [6:0] ITER_LIM = 7'(MAX_ITER);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, CHECK, OUT} state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  load_cnt;
  logic [3:0]  row;
  logic [31:0] max_delta;
  logic [4:0]  out_cnt;
  logic        rd_pend;
  logic        start_pulse;
  logic [3:0]  rd_addr;
  logic        accept;
  logic        exit_run;
  logic        converged;
  logic [6:0]  iter_next;

  assign dp.upd_start = start_pulse;
  assign dp.upd_row   = row;
  assign dp.x_raddr   = rd_addr;

  // Convergence term is always computed; the build switch decides whether it matters.
  assign iter_next = iter_cnt + 7'd1;
  assign converged = EARLY_EXIT && (32'(iter_next) >= MIN_ITER) && (max_delta <= TOL);
  assign exit_run  = (iter_next == ITER_LIM) || converged;

  // Next-state decode and b-beat acceptance.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_en) begin
          accept     = 1'b1;
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        if (in_en) begin
          accept = 1'b1;
          if (load_cnt == 4'd15) begin
            next_state = ISSUE;
          end else begin
            next_state = LOAD;
          end
        end else begin
          next_state = LOAD;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (dp.upd_done) begin
          if (row == LAST_ROW) begin
            next_state = CHECK;
          end else begin
            next_state = ISSUE;
          end
        end else begin
          next_state = WAIT;
        end
      end
      CHECK: begin
        if (exit_run) begin
          next_state = OUT;
        end else begin
          next_state = ISSUE;
        end
      end
      OUT: begin
        if (out_cnt == 5'd17) begin
          next_state = IDLE;
        end else begin
          next_state = OUT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  // b-buffer write path: one registered write per accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_we     <= 1'b0;
      b_waddr  <= 4'd0;
      b_wdata  <= 16'd0;
      load_cnt <= 4'd0;
    end else begin
      b_we <= accept;
      if (accept) begin
        b_waddr  <= load_cnt;
        b_wdata  <= b_in;
        load_cnt <= load_cnt + 4'd1;
      end
    end
  end

  // Row sequencing, iteration count and per-iteration max |dx|.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row         <= 4'd0;
      max_delta   <= 32'd0;
      iter_cnt    <= 7'd0;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= (state == ISSUE);
      if (state == IDLE && in_en) begin
        row       <= 4'd0;
        max_delta <= 32'd0;
        iter_cnt  <= 7'd0;
      end
      if (state == WAIT && dp.upd_done) begin
        if (dp.upd_delta > max_delta) begin
          max_delta <= dp.upd_delta;
        end
        row <= (row == LAST_ROW) ? 4'd0 : row + 4'd1;
      end
      if (state == CHECK) begin
        iter_cnt <= iter_next;
        if (!exit_run) begin
          max_delta <= 32'd0;
        end
      end
    end
  end

  // Output streaming: address 0..15, one-cycle memory latency, registered data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt   <= 5'd0;
      rd_addr   <= 4'd0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      x_out     <= 32'd0;
    end else begin
      if (state == OUT) begin
        out_cnt <= out_cnt + 5'd1;
        if (out_cnt < 5'd15) begin
          rd_addr <= out_cnt[3:0] + 4'd1;
        end
      end else begin
        out_cnt <= 5'd0;
        rd_addr <= 4'd0;
      end
      rd_pend   <= (state == OUT) && (out_cnt < 5'd16);
      out_valid <= rd_pend;
      x_out     <= rd_pend ? dp.x_rdata : 32'd0;
    end
  end

endmodule
